// File: rtl/mem_wait_arbiter.sv
// Round-robin arbiter for one fixed-latency memory port shared by fetch (A) and load/store (B).
// Optional owner-abort on request drop is compiled in with MEM_WAIT_ARBITER_ABORT_EN.
module mem_wait_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_req_a,
  input  logic       i_req_b,
  output logic       o_gnt_a,
  output logic       o_gnt_b,
  output logic       o_busy,
  output logic [3:0] o_cont,
  output logic       o_done,
  output logic       o_done_id,
  output logic       o_abort
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] LP_TERM = 4'(WAIT_CYCLES);

  state_t     r_state, w_state_nx;
  logic       r_owner, w_owner_nx;
  logic       r_last, w_last_nx;
  logic [3:0] r_cont, w_cont_nx;
  logic       r_gnt_a, r_gnt_b, r_busy, r_done, r_done_id;

`ifdef MEM_WAIT_ARBITER_ABORT_EN
  logic w_owner_req;
  logic w_abort_nx;
  logic r_abort;
  assign w_owner_req = r_owner ? i_req_b : i_req_a;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_cont_nx  = 4'd0;
`ifdef MEM_WAIT_ARBITER_ABORT_EN
    w_abort_nx = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not own the port last time wins
        if (i_req_a && i_req_b) begin
          w_owner_nx = ~r_last;
          w_state_nx = S_BUSY;
        end else if (i_req_a) begin
          w_owner_nx = 1'b0;
          w_state_nx = S_BUSY;
        end else if (i_req_b) begin
          w_owner_nx = 1'b1;
          w_state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
`ifdef MEM_WAIT_ARBITER_ABORT_EN
        if (!w_owner_req) begin
          w_state_nx = S_IDLE;
          w_last_nx  = r_owner;
          w_abort_nx = 1'b1;
        end else
`endif
        if (r_cont == LP_TERM) begin
          w_state_nx = S_DONE;
        end else begin
          w_cont_nx = r_cont + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_last_nx  = r_owner;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state decode
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_cont    <= 4'd0;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_owner   <= w_owner_nx;
      r_last    <= w_last_nx;
      r_cont    <= w_cont_nx;
      r_gnt_a   <= (w_state_nx != S_IDLE) && !w_owner_nx;
      r_gnt_b   <= (w_state_nx != S_IDLE) && w_owner_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= (w_state_nx == S_DONE);
      r_done_id <= (w_state_nx == S_DONE) && w_owner_nx;
    end
  end

`ifdef MEM_WAIT_ARBITER_ABORT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_abort_nx;
    end
  end
  assign o_abort = r_abort;
`else
  assign o_abort = 1'b0;
`endif

  assign o_gnt_a   = r_gnt_a;
  assign o_gnt_b   = r_gnt_b;
  assign o_busy    = r_busy;
  assign o_cont    = r_cont;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;

endmodule

// File: tb/tb_mem_wait_arbiter.sv
// Bench for mem_wait_arbiter: two instances (WAIT_CYCLES 4 and 1) driven by shared stimulus,
// checked every cycle against a grant-age reference model plus directed literal checks.
module tb_mem_wait_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       gnt_a [2];
  logic       gnt_b [2];
  logic       busy [2];
  logic [3:0] cont [2];
  logic       done [2];
  logic       done_id [2];
  logic       abort [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

`ifdef MEM_WAIT_ARBITER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_wait_arbiter #(.WAIT_CYCLES(4)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_req_a(req_a), .i_req_b(req_b),
    .o_gnt_a(gnt_a[0]), .o_gnt_b(gnt_b[0]), .o_busy(busy[0]), .o_cont(cont[0]),
    .o_done(done[0]), .o_done_id(done_id[0]), .o_abort(abort[0])
  );

  mem_wait_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_req_a(req_a), .i_req_b(req_b),
    .o_gnt_a(gnt_a[1]), .o_gnt_b(gnt_b[1]), .o_busy(busy[1]), .o_cont(cont[1]),
    .o_done(done[1]), .o_done_id(done_id[1]), .o_abort(abort[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a grant is an owner plus an age counted from the grant cycle.
  // Ages 0..W are the wait phase, age W+1 is the completion cycle.
  int unsigned W [2] = '{4, 1};
  bit m_act [2];
  bit m_own [2];
  bit m_last [2];
  bit m_abort [2];
  int m_age [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0; m_own[i] = 1'b0; m_last[i] = 1'b1; m_abort[i] = 1'b0; m_age[i] = 0;
      end else begin
        m_abort[i] = 1'b0;
        if (m_act[i]) begin
          if (m_age[i] == int'(W[i]) + 1) begin
            m_act[i] = 1'b0; m_last[i] = m_own[i];
          end else if (ABORT_EN && !(m_own[i] ? req_b : req_a)) begin
            m_act[i] = 1'b0; m_last[i] = m_own[i]; m_abort[i] = 1'b1;
          end else begin
            m_age[i]++;
          end
        end else if (req_a || req_b) begin
          m_own[i] = (req_a && req_b) ? !m_last[i] : req_b;
          m_act[i] = 1'b1;
          m_age[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int  e_cont;
        bit  e_done;
        e_cont = (m_act[i] && m_age[i] <= int'(W[i])) ? m_age[i] : 0;
        e_done = m_act[i] && (m_age[i] == int'(W[i]) + 1);
        chk($sformatf("dut%0d gnt_a", i), int'(gnt_a[i]), int'(m_act[i] && !m_own[i]));
        chk($sformatf("dut%0d gnt_b", i), int'(gnt_b[i]), int'(m_act[i] && m_own[i]));
        chk($sformatf("dut%0d busy", i), int'(busy[i]), int'(m_act[i]));
        chk($sformatf("dut%0d cont", i), int'(cont[i]), e_cont);
        chk($sformatf("dut%0d done", i), int'(done[i]), int'(e_done));
        chk($sformatf("dut%0d abort", i), int'(abort[i]), int'(m_abort[i]));
        chk($sformatf("dut%0d gnt_excl", i), int'(gnt_a[i] && gnt_b[i]), 0);
        if (e_done) chk($sformatf("dut%0d done_id", i), int'(done_id[i]), int'(m_own[i]));
      end
    end
  end

  int dq_id [$];
  int dq_cyc [$];
  bit found;

  initial begin
    // Phase 1: reset state and a single A access
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst gnt_a", int'(gnt_a[0]), 0);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst cont", int'(cont[0]), 0);
    chk("rst done", int'(done[0]), 0);
    rst = 1'b0;
    req_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("p1 gnt_a c%0d", c), int'(gnt_a[0]), (c <= 6) ? 1 : 0);
      chk($sformatf("p1 cont c%0d", c), int'(cont[0]), (c <= 5) ? c - 1 : 0);
      chk($sformatf("p1 done c%0d", c), int'(done[0]), (c == 6) ? 1 : 0);
      if (c == 6) chk("p1 done_id", int'(done_id[0]), 0);
      if (c <= 4) begin
        chk($sformatf("p1 w1 gnt_a c%0d", c), int'(gnt_a[1]), (c <= 3) ? 1 : 0);
        chk($sformatf("p1 w1 cont c%0d", c), int'(cont[1]), (c == 2) ? 1 : 0);
        chk($sformatf("p1 w1 done c%0d", c), int'(done[1]), (c == 3) ? 1 : 0);
      end
      if (c == 6) req_a = 1'b0;
    end

    // Phase 2: both requests held, grants alternate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done[0]) begin dq_id.push_back(int'(done_id[0])); dq_cyc.push_back(c); end
    end
    chk("p2 done count", (dq_id.size() >= 4) ? 1 : 0, 1);
    if (dq_id.size() >= 4) begin
      chk("p2 first done cycle", dq_cyc[0], 6);
      for (int k = 0; k < 4; k++) chk($sformatf("p2 done_id %0d", k), dq_id[k], k % 2);
      for (int k = 1; k < 4; k++) chk($sformatf("p2 gap %0d", k), dq_cyc[k] - dq_cyc[k-1], 7);
    end

    // Phase 3: reset during a B access, then a tie goes to A
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0; req_b = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (gnt_b[0] && cont[0] == 4'd3) found = 1'b1;
    end
    chk("p3 reached cont3", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("p3 gnt_b", int'(gnt_b[0]), 0);
    chk("p3 cont", int'(cont[0]), 0);
    chk("p3 busy", int'(busy[0]), 0);
    chk("p3 done", int'(done[0]), 0);
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    chk("p3 tie gnt_a", int'(gnt_a[0]), 1);
    chk("p3 tie gnt_b", int'(gnt_b[0]), 0);

    // Phase 4: owner drops its request mid-access
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0; req_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("p4 cont1", int'(cont[0]), 1);
    req_a = 1'b0;
    @(negedge clk);
`ifdef MEM_WAIT_ARBITER_ABORT_EN
    chk("p4 abort", int'(abort[0]), 1);
    chk("p4 gnt_a", int'(gnt_a[0]), 0);
    chk("p4 done", int'(done[0]), 0);
`else
    chk("p4 abort", int'(abort[0]), 0);
    chk("p4 gnt_a", int'(gnt_a[0]), 1);
    chk("p4 cont", int'(cont[0]), 2);
`endif
    repeat (3) @(negedge clk);
`ifdef MEM_WAIT_ARBITER_ABORT_EN
    chk("p4 c6 done", int'(done[0]), 0);
`else
    chk("p4 c6 done", int'(done[0]), 1);
    chk("p4 c6 done_id", int'(done_id[0]), 0);
`endif

    // Phase 5: randomized requests with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (req_a) begin
        if ($urandom_range(0, 9) == 0) req_a = 1'b0;
      end else if ($urandom_range(0, 9) < 4) begin
        req_a = 1'b1;
      end
      if (req_b) begin
        if ($urandom_range(0, 9) == 0) req_b = 1'b0;
      end else if ($urandom_range(0, 9) < 4) begin
        req_b = 1'b1;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
